// File: rtl/credit_tracker_pkg.sv
// rtl/credit_tracker_pkg.sv - shared widths for the credit tracker, derived from the global macros
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 3
`endif
`ifndef VC_INDEX_WIDTH
`define VC_INDEX_WIDTH 3
`endif
`ifndef NULL_PC
`define NULL_PC 3'd7
`endif
`ifndef NUM_VC
`define NUM_VC 4
`endif

package credit_tracker_pkg;
  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int VC_W   = `VC_INDEX_WIDTH;
  localparam int NUM_VC = `NUM_VC;
endpackage

// File: rtl/credit_cnt.sv
// rtl/credit_cnt.sv - single-VC saturating credit counter with underflow/overflow pulses
module credit_cnt
  import credit_tracker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] count,
  output logic              underflow,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] FULL = ADDR_W'(DEPTH);

  logic [ADDR_W-1:0] count_q, count_d;

  // Next count: a simultaneous send and credit cancel; out-of-range moves hold and pulse an error
  always_comb begin
    count_d   = count_q;
    underflow = 1'b0;
    overflow  = 1'b0;
    if (dec && !inc) begin
      if (count_q == '0) underflow = 1'b1;
      else               count_d   = count_q - ADDR_W'(1);
    end else if (inc && !dec) begin
      if (count_q == FULL) overflow = 1'b1;
      else                 count_d  = count_q + ADDR_W'(1);
    end
  end

  // Counter register; reset refills the VC to a full buffer
  always_ff @(posedge clk) begin
    if (reset) count_q <= FULL;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/credit_tracker.sv
// rtl/credit_tracker.sv - per-VC downstream credit tracking for one router output port
module credit_tracker
  import credit_tracker_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int CRED_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              send_valid,
  input  logic [VC_W-1:0]   send_vc,
  input  logic              credit_valid,
  input  logic [VC_W-1:0]   credit_vc,
  output logic [ADDR_W-1:0] vc0_credit,
  output logic [ADDR_W-1:0] vc1_credit,
  output logic [ADDR_W-1:0] vc2_credit,
  output logic [ADDR_W-1:0] vc3_credit,
  output logic              underflow_err,
  output logic              overflow_err
);

  logic              cred_valid_q, cred_valid_d;
  logic [VC_W-1:0]   cred_vc_q, cred_vc_d;
  logic              underflow_err_q, underflow_err_d;
  logic              overflow_err_q, overflow_err_d;
  logic              app_valid;
  logic [VC_W-1:0]   app_vc;
  logic [NUM_VC-1:0] inc, dec, under, over;
  logic [ADDR_W-1:0] count [NUM_VC];

  // Credit-return pipeline input: capture the raw credit every cycle
  always_comb begin
    cred_valid_d = credit_valid;
    cred_vc_d    = credit_vc;
  end

  // Credit-return pipeline register; reset drops any credit in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      cred_valid_q <= 1'b0;
      cred_vc_q    <= '0;
    end else begin
      cred_valid_q <= cred_valid_d;
      cred_vc_q    <= cred_vc_d;
    end
  end

  assign app_valid = (CRED_LAT == 1) ? cred_valid_q : credit_valid;
  assign app_vc    = (CRED_LAT == 1) ? cred_vc_q    : credit_vc;

  // Decode sends and applied credits to per-VC strobes; VC indices above 3 match nothing
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      inc[i] = app_valid  && (app_vc  == VC_W'(i));
      dec[i] = send_valid && (send_vc == VC_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_cnt
    credit_cnt #(.DEPTH(DEPTH)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc[g]),
      .dec       (dec[g]),
      .count     (count[g]),
      .underflow (under[g]),
      .overflow  (over[g])
    );
  end

  // Sticky error flags accumulate any counter's error pulse
  always_comb begin
    underflow_err_d = underflow_err_q | (|under);
    overflow_err_d  = overflow_err_q  | (|over);
  end

  // Error flag registers, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow_err_q <= 1'b0;
      overflow_err_q  <= 1'b0;
    end else begin
      underflow_err_q <= underflow_err_d;
      overflow_err_q  <= overflow_err_d;
    end
  end

  assign vc0_credit    = count[0];
  assign vc1_credit    = count[1];
  assign vc2_credit    = count[2];
  assign vc3_credit    = count[3];
  assign underflow_err = underflow_err_q;
  assign overflow_err  = overflow_err_q;

endmodule

// File: tb/tb_credit_tracker.sv
// tb/tb_credit_tracker.sv - directed self-checking bench for credit_tracker
module tb_credit_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       send_valid;
  logic [2:0] send_vc;
  logic       credit_valid;
  logic [2:0] credit_vc;

  logic [2:0] vc0_credit, vc1_credit, vc2_credit, vc3_credit;
  logic       underflow_err, overflow_err;
  logic [2:0] l0_vc0, l0_vc1, l0_vc2, l0_vc3;
  logic       l0_under, l0_over;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  credit_tracker #(.DEPTH(4), .CRED_LAT(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .send_valid    (send_valid),
    .send_vc       (send_vc),
    .credit_valid  (credit_valid),
    .credit_vc     (credit_vc),
    .vc0_credit    (vc0_credit),
    .vc1_credit    (vc1_credit),
    .vc2_credit    (vc2_credit),
    .vc3_credit    (vc3_credit),
    .underflow_err (underflow_err),
    .overflow_err  (overflow_err)
  );

  credit_tracker #(.DEPTH(4), .CRED_LAT(0)) dut_lat0 (
    .clk           (clk),
    .reset         (reset),
    .send_valid    (send_valid),
    .send_vc       (send_vc),
    .credit_valid  (credit_valid),
    .credit_vc     (credit_vc),
    .vc0_credit    (l0_vc0),
    .vc1_credit    (l0_vc1),
    .vc2_credit    (l0_vc2),
    .vc3_credit    (l0_vc3),
    .underflow_err (l0_under),
    .overflow_err  (l0_over)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    send_valid   = 1'b0;
    send_vc      = 3'd0;
    credit_valid = 1'b0;
    credit_vc    = 3'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset: all counters full, flags clear
    do_reset();
    check("rst_vc0", vc0_credit, 4);
    check("rst_vc1", vc1_credit, 4);
    check("rst_vc2", vc2_credit, 4);
    check("rst_vc3", vc3_credit, 4);
    check("rst_under", underflow_err, 0);
    check("rst_over", overflow_err, 0);
    check("rst_l0_vc0", l0_vc0, 4);

    // Drain VC2 then one send too many
    send_valid = 1'b1;
    send_vc    = 3'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("drain_vc2_%0d", i), vc2_credit, 3 - i);
    end
    check("drain_no_under", underflow_err, 0);
    tick();
    check("drain5_vc2", vc2_credit, 0);
    check("drain5_under", underflow_err, 1);
    idle();
    tick();
    tick();
    check("under_sticky", underflow_err, 1);
    check("drain_vc2_hold", vc2_credit, 0);

    // Credit latency: VC1 at 2, credit at t visible at t+2 (t+1 for CRED_LAT=0)
    do_reset();
    send_valid = 1'b1;
    send_vc    = 3'd1;
    tick();
    tick();
    idle();
    check("lat_pre_vc1", vc1_credit, 2);
    credit_valid = 1'b1;
    credit_vc    = 3'd1;
    tick();
    idle();
    check("lat_t1_vc1", vc1_credit, 2);
    check("lat0_t1_vc1", l0_vc1, 3);
    tick();
    check("lat_t2_vc1", vc1_credit, 3);

    // Same-VC collision at 0: credit issued with the last draining send lands with the next send
    send_valid = 1'b1;
    send_vc    = 3'd0;
    tick();
    tick();
    tick();
    check("coll_pre_vc0", vc0_credit, 1);
    credit_valid = 1'b1;
    credit_vc    = 3'd0;
    tick();
    check("coll_drained_vc0", vc0_credit, 0);
    credit_valid = 1'b0;
    tick();
    check("coll0_vc0", vc0_credit, 0);
    check("coll0_no_under", underflow_err, 0);

    // Same-VC collision at DEPTH on VC3
    idle();
    credit_valid = 1'b1;
    credit_vc    = 3'd3;
    tick();
    credit_valid = 1'b0;
    send_valid   = 1'b1;
    send_vc      = 3'd3;
    tick();
    idle();
    check("coll4_vc3", vc3_credit, 4);
    check("coll4_no_over", overflow_err, 0);

    // Overflow on VC3
    credit_valid = 1'b1;
    credit_vc    = 3'd3;
    tick();
    idle();
    tick();
    check("ovf_vc3", vc3_credit, 4);
    check("ovf_flag", overflow_err, 1);

    // Out-of-range VC indices are ignored
    send_valid   = 1'b1;
    send_vc      = 3'd5;
    credit_valid = 1'b1;
    credit_vc    = 3'd6;
    tick();
    tick();
    idle();
    tick();
    check("oor_vc0", vc0_credit, 0);
    check("oor_vc1", vc1_credit, 3);
    check("oor_vc2", vc2_credit, 4);
    check("oor_vc3", vc3_credit, 4);
    check("oor_no_under", underflow_err, 0);
    check("ovf_sticky", overflow_err, 1);

    // Different-VC send and credit in the same cycle both apply
    send_valid   = 1'b1;
    send_vc      = 3'd2;
    credit_valid = 1'b1;
    credit_vc    = 3'd0;
    tick();
    idle();
    tick();
    check("diff_vc2", vc2_credit, 3);
    check("diff_vc0", vc0_credit, 1);

    // Reset mid-flight discards the in-flight credit
    do_reset();
    send_valid = 1'b1;
    send_vc    = 3'd0;
    tick();
    idle();
    check("mid_pre_vc0", vc0_credit, 3);
    credit_valid = 1'b1;
    credit_vc    = 3'd0;
    tick();
    credit_valid = 1'b0;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_t2_vc0", vc0_credit, 4);
    tick();
    check("mid_t3_vc0", vc0_credit, 4);
    check("mid_t3_no_over", overflow_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/credit_tracker.md
CREDIT_TRACKER -- requirements
Module: credit_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 4: flit slots per VC in the downstream input buffer; legal range 1 .. 2^`ADDR_WIDTH - 1.
REQ-002 SHALL have parameter CRED_LAT, default 1: credit-return pipeline stages; legal values 0 or 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port send_valid, input, 1 bit: a flit departs this output port this cycle (switch arbiter winner is not `NULL_PC).
REQ-006 SHALL have port send_vc, input, `VC_INDEX_WIDTH bits: downstream VC of the departing flit (the arbiter's vcNew).
REQ-007 SHALL have port credit_valid, input, 1 bit: the downstream router freed one slot.
REQ-008 SHALL have port credit_vc, input, `VC_INDEX_WIDTH bits: VC of the returned credit.
REQ-009 SHALL have ports vc0_credit, vc1_credit, vc2_credit and vc3_credit, output, `ADDR_WIDTH bits each: registered free-slot counts, fed directly to the switch arbiter.
REQ-010 SHALL have port underflow_err, output, 1 bit: sticky flag, a send was made to a VC holding 0 credits.
REQ-011 SHALL have port overflow_err, output, 1 bit: sticky flag, a credit was returned to a VC already holding DEPTH.

Function
REQ-012 SHALL keep one credit counter per VC (4 counters); each output is that counter's register value, with no combinational path from inputs to outputs.
REQ-013 SHALL apply a send on the edge that samples it: the counter for send_vc decrements by 1, so the arbiter sees the new value the next cycle.
REQ-014 SHALL, when CRED_LAT=1, register credit_valid/credit_vc once and apply the increment one edge later; when CRED_LAT=0, apply it on the sampling edge.
REQ-015 SHALL, when a send and an applied credit hit the same VC in one cycle, leave that counter unchanged (net 0), never out of range.
REQ-016 SHALL, when a send and an applied credit hit different VCs in one cycle, apply both.
REQ-017 SHALL, on a send to a counter at 0: hold the counter at 0, set underflow_err, and process the other events that cycle normally.
REQ-018 SHALL, on an applied credit to a counter at DEPTH (with no same-VC send): hold the counter at DEPTH, set overflow_err.
REQ-019 SHALL ignore send_vc or credit_vc values greater than 3: no counter changes and no error flag is set.
REQ-020 SHALL hold underflow_err and overflow_err at 1 until reset once set.
REQ-021 SHALL have latency send->output of 1 cycle and credit->output of 1+CRED_LAT cycles.

Reset
REQ-022 SHALL, while reset=1 at a clock edge, load every counter with DEPTH, clear both error flags and clear the credit pipeline register.
REQ-023 SHALL discard any send or credit presented in a cycle where reset=1 (reset dominates; a credit in flight at mid-operation reset is lost).
REQ-024 SHALL drive outputs vcN_credit = DEPTH and flags = 0 in the first cycle after reset deasserts.

Structure
REQ-025 SHALL take `ADDR_WIDTH, `VC_INDEX_WIDTH and `NULL_PC from global.vh; no new global macros except `NUM_VC (=4), which is added there.
REQ-026 SHALL instantiate one sub-module, credit_cnt (single-VC saturating up/down counter with error outputs), 4 times.
REQ-027 SHALL be implemented in 120-250 lines of RTL total.

Verification
REQ-028 Reset check: DEPTH=4, assert reset 2 cycles -> all vcN_credit=4, flags 0.
REQ-029 Drain check: send_vc=2 for 4 consecutive cycles -> vc2_credit steps 3,2,1,0, each one cycle after its send; a 5th send -> vc2_credit stays 0, underflow_err=1 and stays 1.
REQ-030 Credit latency check: CRED_LAT=1, vc1_credit=2, credit_valid on VC1 at cycle t -> vc1_credit=3 visible at t+2.
REQ-031 Same-VC collision check: vc0_credit=0, send VC0 and applied credit VC0 in the same cycle -> vc0_credit stays 0, no underflow_err; same case at 4 -> stays 4, no overflow_err.
REQ-032 Overflow check: vc3_credit=4, credit returned to VC3 -> stays 4, overflow_err=1; send_vc=5 -> no change.
REQ-033 Reset mid-flight check: credit on VC0 at t, reset at t+1 -> vc0_credit=DEPTH at t+2 and t+3 (credit discarded).
